// File: rtl/fir_mac_pkg.sv
// Shared state encoding and arithmetic helpers for the time-multiplexed FIR MAC.
// Widths of the accumulator and the scaled/saturated output are derived here.
package fir_mac_pkg;

  // Wide enough for any accumulator this block is configured with.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } fir_state_e;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_res_t;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int unsigned chan_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Floor shift followed by clipping to the signed out_w range.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int unsigned             shift,
                                         input int unsigned             out_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_res_t                r;
    one     = SAT_W'(1);
    shifted = acc >>> shift;
    max_v   = (one <<< (out_w - 1)) - one;
    min_v   = -max_v - one;
    if (shifted > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v;
    end else if (shifted < min_v) begin
      r.sat   = 1'b1;
      r.value = min_v;
    end else begin
      r.sat   = 1'b0;
      r.value = shifted;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_mc_if.sv
// Sample, coefficient and result signals of the multi-channel FIR MAC.
// The control/front-end side uses master, the filter uses slave.
interface fir_mac_mc_if
  import fir_mac_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned TAPS     = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUT_W    = 16
);
  localparam int unsigned CHAN_W = chan_width(CHANNELS);
  localparam int unsigned TAP_W  = $clog2(TAPS);

  logic                     clear;
  logic                     in_valid;
  logic                     in_ready;
  logic [CHAN_W-1:0]        in_chan;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [TAP_W-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic [CHAN_W-1:0]        out_chan;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  modport master (
    output clear, in_valid, in_chan, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_chan, out_data, out_sat
  );

  modport slave (
    input  clear, in_valid, in_chan, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_chan, out_data, out_sat
  );

endinterface

// File: rtl/fir_hist_mem.sv
// Per-channel circular sample history. Owns the write pointers; the read port
// addresses samples by age (tap 0 is the sample at the current write pointer).
module fir_hist_mem #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TAPS     = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CHAN_W   = 1,
  parameter int unsigned TAP_W    = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [CHAN_W-1:0]        wr_chan,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     advance,
  input  logic [CHAN_W-1:0]        adv_chan,
  input  logic [CHAN_W-1:0]        rd_chan,
  input  logic [TAP_W-1:0]         rd_tap,
  output logic signed [DATA_W-1:0] rd_data
);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  logic signed [DATA_W-1:0] hist_q [CHANNELS][TAPS];
  logic [TAP_W-1:0]         wptr_q [CHANNELS];
  logic [TAP_W-1:0]         rd_ptr;
  logic [TAP_W-1:0]         rd_idx;

  // (wptr - tap) mod TAPS without a divider; also correct for non power-of-two TAPS.
  always_comb begin
    rd_ptr = wptr_q[rd_chan];
    if (rd_tap > rd_ptr) begin
      rd_idx = rd_ptr + TAP_W'(TAPS) - rd_tap;
    end else begin
      rd_idx = rd_ptr - rd_tap;
    end
    rd_data = hist_q[rd_chan][rd_idx];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
      end
    end else begin
      if (wr_en) begin
        hist_q[wr_chan][wptr_q[wr_chan]] <= wr_data;
      end
      if (advance) begin
        wptr_q[adv_chan] <= (wptr_q[adv_chan] == LAST_TAP) ? '0 : wptr_q[adv_chan] + TAP_W'(1);
      end
    end
  end

endmodule

// File: rtl/fir_mac_mc.sv
// Multi-channel FIR filter sharing one multiply-accumulate unit: one tap per
// cycle, then a scaled and saturated result strobed on out_valid.
module fir_mac_mc
  import fir_mac_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned TAPS      = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = 7
) (
  input logic          clk,
  input logic          nRst,
  fir_mac_mc_if.slave  bus
);
  localparam int unsigned       CHAN_W    = chan_width(CHANNELS);
  localparam int unsigned       TAP_W     = $clog2(TAPS);
  localparam int unsigned       PROD_W    = DATA_W + COEF_W;
  localparam int unsigned       ACC_W     = acc_width(DATA_W, COEF_W, TAPS);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(TAPS - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  fir_state_e               state_q;
  logic [CHAN_W-1:0]        chan_q;
  logic [TAP_W-1:0]         k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic                     out_valid_q;
  logic [CHAN_W-1:0]        out_chan_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     out_sat_q;

  logic                     hist_we;
  logic                     hist_adv;
  logic signed [DATA_W-1:0] hist_rd;
  logic signed [COEF_W-1:0] coef_cur;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  sat_res_t                 res;

  // Samples for channels that do not exist are accepted and dropped.
  assign hist_we  = (state_q == StIdle) && bus.in_valid && !bus.clear &&
                    (bus.in_chan <= LAST_CHAN);
  assign hist_adv = (state_q == StDone);

  fir_hist_mem #(
    .DATA_W  (DATA_W),
    .TAPS    (TAPS),
    .CHANNELS(CHANNELS),
    .CHAN_W  (CHAN_W),
    .TAP_W   (TAP_W)
  ) u_hist (
    .clk     (clk),
    .nRst    (nRst),
    .clear   (bus.clear),
    .wr_en   (hist_we),
    .wr_chan (bus.in_chan),
    .wr_data (bus.in_data),
    .advance (hist_adv),
    .adv_chan(chan_q),
    .rd_chan (chan_q),
    .rd_tap  (k_q),
    .rd_data (hist_rd)
  );

  assign coef_cur = coef_q[k_q];
  assign coef_ext = {{DATA_W{coef_cur[COEF_W-1]}}, coef_cur};
  assign samp_ext = {{COEF_W{hist_rd[DATA_W-1]}}, hist_rd};
  assign prod     = coef_ext * samp_ext;
  assign acc_next = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign res      = sat_shift({{(SAT_W - ACC_W){acc_next[ACC_W-1]}}, acc_next}, OUT_SHIFT, OUT_W);

  // The result is registered on the last MAC step so out_valid is visible in DONE.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StIdle;
      chan_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (bus.clear) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.coef_we && (bus.coef_addr <= LAST_TAP)) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
          end
          if (hist_we) begin
            chan_q  <= bus.in_chan;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          k_q   <= k_q + TAP_W'(1);
          if (k_q == LAST_TAP) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_chan_q  <= chan_q;
            out_data_q  <= res.value[OUT_W-1:0];
            out_sat_q   <= res.sat;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: doc/fir_mac_mc.md
# fir_mac_mc

Time-multiplexed, multi-channel FIR filter built around a single multiply-accumulate unit. Signed samples for up to CHANNELS independent streams share one programmable coefficient bank. Each accepted sample produces one filtered, scaled and saturated output after a fixed latency. The block sits between the sample front-end and downstream DSP stages; coefficients are written by the control logic through a simple addressed port.

## Interface
- DATA_W, 16, signed sample width
- COEF_W, 8, signed coefficient width
- TAPS, 16, filter length (≥2)
- CHANNELS, 2, independent channels (≥1)
- OUT_W, 16, output width after scaling
- OUT_SHIFT, 7, arithmetic right shift applied to accumulator
- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of all history and pointers
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_chan  in  clog2(CHANNELS) (min 1)  channel of offered sample
- in_data  in  DATA_W  signed sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index
- coef_data  in  COEF_W  signed coefficient
- out_valid  out  1  one-cycle result strobe
- out_chan  out  clog2(CHANNELS)  channel of result
- out_data  out  OUT_W  signed filtered result
- out_sat  out  1  result was saturated (qualified by out_valid)

## Operation
- Storage:
  - Per-channel circular history of TAPS samples.
  - Per-channel write pointer wptr[c].
  - Shared coefficient array coef[0..TAPS-1].
- Reset (nRst low): history, coefficients, pointers and accumulator = 0. State IDLE. Outputs: in_ready=1 (after release), out_valid=0, out_chan=0, out_data=0, out_sat=0.
- FSM states are IDLE, MAC and DONE.
  - IDLE: in_ready=1. On in_valid, write in_data to hist[in_chan][wptr], latch the channel, set acc=0 and k=0, then go to MAC.
  - MAC: one step per cycle, acc += coef[k] * hist[ch][(wptr[ch]-k) mod TAPS]. After k=TAPS-1, go to DONE.
  - DONE: out_valid=1. Load out_data/out_sat, out_chan=ch. wptr[ch] = (wptr[ch]+1) mod TAPS (wrap at TAPS-1→0). Go to IDLE.
- Arithmetic:
  - Product width is DATA_W+COEF_W.
  - ACC_W = DATA_W+COEF_W+clog2(TAPS); accumulation never overflows.
  - Output = acc >>> OUT_SHIFT (floor), saturated to the signed OUT_W range. out_sat=1 when clipped.
- in_chan ≥ CHANNELS: the handshake completes but the sample is discarded. No MAC, no output, and the block stays in IDLE.
- coef_we is honoured only in IDLE and is dropped silently in MAC/DONE. If coef_we and a sample are accepted in the same IDLE cycle, the write lands at that edge and the starting MAC uses the new value.
- clear:
  - In any state it zeroes all history and pointers and returns to IDLE.
  - Any result in flight is dropped (no out_valid).
  - Coefficients are kept. clear has priority over in_valid.
- Channels never share history. A sample on one channel does not move the pointer of another.

## Timing
- Accept at edge E0. MAC accumulates on edges E1..E_TAPS. out_valid is high for the single cycle sampled at edge E_(TAPS+1).
- in_ready is low from after E0 until after E_(TAPS+1).
- Minimum sample spacing is TAPS+2 cycles; back-to-back accepts are possible at that rate.
- Outputs are registered and hold their value until the next DONE; out_valid is a pulse.
- nRst asserted mid-operation aborts immediately to reset values; no partial output is produced.

## Structure
- Package fir_mac_pkg holds:
  - the state enum (IDLE, MAC, DONE);
  - the ACC_W derivation function;
  - the saturating shift function, sat_shift(acc, OUT_SHIFT, OUT_W).
- Sub-module fir_hist_mem: per-channel circular history with a write port and a read port (channel, tap offset). It owns the wptr array and its wrap, with advance and clear inputs.

## Test plan
- **Impulse:** TAPS=4, coef {1,2,3,4}, OUT_SHIFT=0. Channel 0 receives 1,0,0,0 → outputs 1,2,3,4 on channel 0. Each out_valid arrives exactly TAPS+1 cycles after accept.
- **Channel isolation:** CHANNELS=2, coef all 1. ch0 receives 5,5 and ch1 receives 7 interleaved → ch0 results 5,10; ch1 result 7.
- **Saturation:** DATA_W=16, coef all 127, TAPS=16, OUT_SHIFT=0, OUT_W=16. Feed 16 samples of 32767 → out_data=32767 and out_sat=1. A final input of −32768 with coef −128 gives a positive clip.
- **Wrap-around:** TAPS=4, 6 samples on one channel. The pointer wraps and output 6 = dot(coef, last four samples reversed).
- **Coef write gating:** coef_we pulsed during MAC → value unchanged (a subsequent impulse confirms). coef_we in IDLE together with in_valid → the new coefficient is used in that result.
- **Clear/reset mid-MAC:** clear at MAC step 2 → no out_valid, in_ready=1 next cycle, history zero (an impulse then gives pure coefficients). nRst mid-MAC → all outputs take their reset values.
